// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the button debouncer: the per-channel FSM state type
// and the default qualification length.
package button_debouncer_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 100000;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchronizer, qualification FSM with counter,
// registered edge pulses and a sticky press flag.
//
// state     | meaning
// IDLE_LOW  | stable low, synced input also low
// WAIT_HIGH | stable low, synced input high, qualifying
// IDLE_HIGH | stable high, synced input also high
// WAIT_LOW  | stable high, synced input low, qualifying
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic resetN,
  input  logic raw_i,
  input  logic clear_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o,
  output logic latch_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  // The entry edge consumes the first differing sample, so the last WAIT edge
  // is the one that sees count DEBOUNCE_CYCLES-2 (incremented value = D-1).
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  db_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sync1_q, sync2_q;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic            latch_q, latch_d;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      latch_q <= latch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        cnt_d = '0;
        if (sync2_q) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE_HIGH: begin
        cnt_d = '0;
        if (!sync2_q) state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (sync2_q) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
    // Set dominates clear when both land on the same edge.
    latch_d = rise_d | (latch_q & ~clear_i);
  end

  assign stable_o = (state_q == IDLE_HIGH) || (state_q == WAIT_LOW);
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign latch_o  = latch_q;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel button debouncer: N_CH independent debounce_channel instances
// sharing one clock and reset.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic [N_CH-1:0] rawIn,
  input  logic [N_CH-1:0] clearMask,
  output logic [N_CH-1:0] stable,
  output logic [N_CH-1:0] risePulse,
  output logic [N_CH-1:0] fallPulse,
  output logic [N_CH-1:0] pressLatched
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("button_debouncer: DEBOUNCE_CYCLES must be at least 2");
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .resetN   (resetN),
      .raw_i    (rawIn[g]),
      .clear_i  (clearMask[g]),
      .stable_o (stable[g]),
      .rise_o   (risePulse[g]),
      .fall_o   (fallPulse[g]),
      .latch_o  (pressLatched[g])
    );
  end

endmodule
